// File: rtl/maquina_cafe_param.sv
// Coffee machine sequencer: brews a latched number of cups, refilling the
// reservoir as needed, with abort, fill-timeout fault and fault acknowledge.
module maquina_cafe_param #(
    parameter int CUPS_W   = 3,
    parameter int MOER_CYC = 4,
    parameter int EXTR_CYC = 8,
    parameter int FILL_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CUPS_W-1:0] cups,
    input  logic              agua_enchida,
    input  logic              abort,
    input  logic              ack_erro,
    output logic [3:0]        state,
    output logic              busy,
    output logic              done,
    output logic              erro,
    output logic [CUPS_W-1:0] cups_done
);

    localparam int MAX_A   = (MOER_CYC > EXTR_CYC) ? MOER_CYC : EXTR_CYC;
    localparam int MAX_CYC = (MAX_A > FILL_MAX) ? MAX_A : FILL_MAX;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] MOER_LAST = CNT_W'(MOER_CYC - 1);
    localparam logic [CNT_W-1:0] EXTR_LAST = CNT_W'(EXTR_CYC - 1);
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_MAX - 1);

    typedef enum logic [3:0] {
        IDLE                = 4'd1,
        LIGAR_MAQUINA       = 4'd2,
        VERIFICAR_AGUA      = 4'd3,
        ENCHER_RESERVATORIO = 4'd4,
        MOER_CAFE           = 4'd5,
        COLOCAR_NO_FILTRO   = 4'd6,
        PASSAR_AGITADOR     = 4'd7,
        TAMPEAR             = 4'd8,
        REALIZAR_EXTRACAO   = 4'd9,
        ERRO                = 4'd10
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [CUPS_W-1:0] cups_reg, cups_next;
    logic [CUPS_W-1:0] cups_done_reg, cups_done_next;
    logic [CUPS_W-1:0] cups_done_inc;
    logic              done_next;
    logic              busy_reg, done_reg, erro_reg;

    function automatic logic is_busy(input state_t s);
        is_busy = (s >= LIGAR_MAQUINA) && (s <= REALIZAR_EXTRACAO);
    endfunction

    assign cups_done_inc = cups_done_reg + 1'b1;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = '0;
        cups_next      = cups_reg;
        cups_done_next = cups_done_reg;
        done_next      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && (cups != '0)) begin
                    cups_next      = cups;
                    cups_done_next = '0;
                    state_next     = LIGAR_MAQUINA;
                end
            end
            LIGAR_MAQUINA:  state_next = VERIFICAR_AGUA;
            VERIFICAR_AGUA: state_next = agua_enchida ? MOER_CAFE : ENCHER_RESERVATORIO;
            ENCHER_RESERVATORIO: begin
                cnt_next = cnt_reg + 1'b1;
                if (agua_enchida)
                    state_next = VERIFICAR_AGUA;
                else if (cnt_reg == FILL_LAST)
                    state_next = ERRO;
            end
            MOER_CAFE: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == MOER_LAST)
                    state_next = COLOCAR_NO_FILTRO;
            end
            COLOCAR_NO_FILTRO: state_next = PASSAR_AGITADOR;
            PASSAR_AGITADOR:   state_next = TAMPEAR;
            TAMPEAR:           state_next = REALIZAR_EXTRACAO;
            REALIZAR_EXTRACAO: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == EXTR_LAST) begin
                    cups_done_next = cups_done_inc;
                    if (cups_done_inc == cups_reg) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = VERIFICAR_AGUA;
                    end
                end
            end
            ERRO: begin
                if (ack_erro)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Abort overrides everything in busy states, including a finishing cup.
        if (abort && is_busy(state_reg)) begin
            state_next     = IDLE;
            cups_done_next = cups_done_reg;
            done_next      = 1'b0;
        end

        // Every dwell starts counting from zero on entry.
        if (state_next != state_reg)
            cnt_next = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            cups_reg      <= '0;
            cups_done_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            erro_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            cups_reg      <= cups_next;
            cups_done_reg <= cups_done_next;
            busy_reg      <= is_busy(state_next);
            done_reg      <= done_next;
            erro_reg      <= (state_next == ERRO);
        end
    end

    assign state     = state_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign erro      = erro_reg;
    assign cups_done = cups_done_reg;

endmodule

// File: doc/maquina_cafe_param.md
MAQUINA_CAFE_PARAM -- requirements
Module: maquina_cafe_param

Interface
REQ-001 Parameter CUPS_W, default 3: width of the cup-count request and the cup-count progress output.
REQ-002 Parameter MOER_CYC, default 4: number of cycles spent in MOER_CAFE; legal range is 1 or more.
REQ-003 Parameter EXTR_CYC, default 8: number of cycles spent in REALIZAR_EXTRACAO; legal range is 1 or more.
REQ-004 Parameter FILL_MAX, default 16: maximum consecutive ENCHER_RESERVATORIO cycles with agua_enchida=0 before fault; legal range is 1 or more.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  request to brew; sampled only in IDLE.
REQ-008 cups  in  CUPS_W  number of cups requested; latched when start is accepted.
REQ-009 agua_enchida  in  1  reservoir-full sensor.
REQ-010 abort  in  1  cancel the brew in progress.
REQ-011 ack_erro  in  1  clear the fault.
REQ-012 state  out  4  current state code.
REQ-013 busy  out  1  high when state is neither IDLE nor ERRO.
REQ-014 done  out  1  one-cycle pulse at the end of a complete order.
REQ-015 erro  out  1  high exactly when state is ERRO.
REQ-016 cups_done  out  CUPS_W  number of cups finished in the current or last order.

Function
REQ-017 State codes SHALL be: IDLE=1, LIGAR_MAQUINA=2, VERIFICAR_AGUA=3, ENCHER_RESERVATORIO=4, MOER_CAFE=5, COLOCAR_NO_FILTRO=6, PASSAR_AGITADOR=7, TAMPEAR=8, REALIZAR_EXTRACAO=9, ERRO=10.
REQ-018 Any other state code (0, 11-15) SHALL go to IDLE on the next cycle.
REQ-019 IDLE: start=1 with cups!=0 SHALL latch cups, clear cups_done to 0, and go to LIGAR_MAQUINA.
REQ-020 IDLE: start=1 with cups=0 SHALL be ignored.
REQ-021 LIGAR_MAQUINA SHALL last 1 cycle, then go to VERIFICAR_AGUA.
REQ-022 VERIFICAR_AGUA SHALL last 1 cycle, then go to MOER_CAFE if agua_enchida=1, else ENCHER_RESERVATORIO.
REQ-023 ENCHER_RESERVATORIO SHALL stay while agua_enchida=0, going to VERIFICAR_AGUA in the cycle after agua_enchida=1 is sampled.
REQ-024 The fill counter SHALL be cleared on each entry to ENCHER_RESERVATORIO; after FILL_MAX consecutive cycles with agua_enchida=0, the next state SHALL be ERRO.
REQ-025 MOER_CAFE SHALL last exactly MOER_CYC cycles, then go to COLOCAR_NO_FILTRO.
REQ-026 COLOCAR_NO_FILTRO, PASSAR_AGITADOR and TAMPEAR SHALL last 1 cycle each, in that order, then go to REALIZAR_EXTRACAO.
REQ-027 REALIZAR_EXTRACAO SHALL last exactly EXTR_CYC cycles; on exit, cups_done SHALL increment.
REQ-028 On exit from REALIZAR_EXTRACAO, if the incremented cups_done equals the latched cups, the next state SHALL be IDLE with done=1 in that first IDLE cycle; otherwise the next state SHALL be VERIFICAR_AGUA for the next cup.
REQ-029 abort=1 in any busy state SHALL go to IDLE next cycle, with no done pulse and cups_done held; abort has priority over timeout and normal transitions.
REQ-030 abort=1 SHALL be ignored in IDLE and ERRO.
REQ-031 ERRO SHALL hold until ack_erro=1, then go to IDLE; start SHALL be ignored in ERRO.
REQ-032 start and cups SHALL be ignored while busy; the latched cups value SHALL not change mid-order.
REQ-033 cups_done SHALL hold its value in IDLE until the next accepted start.
REQ-034 The dwell counter width SHALL cover max(MOER_CYC, EXTR_CYC, FILL_MAX) without wrap.

Reset
REQ-035 reset=1 at a clock edge SHALL force state=1, busy=0, done=0, erro=0, cups_done=0, with the latched cups and all counters cleared, from any state including mid-dwell and ERRO.
REQ-036 reset SHALL have priority over all other inputs.

Verification (default parameters)
REQ-037 Reset in state 9 mid-extraction -> next cycle state=1, cups_done=0, done=0.
REQ-038 start=1, cups=1, agua_enchida=1 -> state sequence 2,3,5,5,5,5,6,7,8,9(x8),1 (17 busy cycles), a single done pulse, and cups_done=1.
REQ-039 start=1, cups=3, agua_enchida=1, plus start pulses while busy -> three passes through 3..9, cups_done=1,2,3, exactly one done pulse, and extra starts ignored.
REQ-040 agua_enchida=0 rising after 5 ENCHER cycles -> states 3,4(x5),3,5 and the brew then completes normally.
REQ-041 agua_enchida held at 0 -> 16 cycles in state 4, then state=10 with erro=1 and busy=0; start ignored; ack_erro=1 -> state=1.
REQ-042 abort=1 during the 2nd MOER cycle -> next state=1 with no done pulse; start with cups=0 in IDLE -> state stays 1.
